// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the alu_sched ALU scheduler.
package alu_sched_pkg;

  localparam int unsigned NREQ_DEF     = 4;
  localparam int unsigned ALU_WAIT_DEF = 2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_CMP = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o
);

  localparam int unsigned SW = IW + 1;

  logic [SW-1:0] cand;
  logic          found;

  // Candidate index is kept one bit wider so the wrap compare works for any NREQ.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = SW'(ptr_i) + SW'(k);
      if (cand >= SW'(NREQ)) begin
        cand = cand - SW'(NREQ);
      end
      if (!found && req_i[cand[IW-1:0]]) begin
        found                   = 1'b1;
        grant_o[cand[IW-1:0]]   = 1'b1;
        idx_o                   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one 4-bit ALU between NREQ requesters.
// Define ALU_SCHED_CNT_EN to add the saturating op_count output.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter  int unsigned NREQ     = NREQ_DEF,
  parameter  int unsigned ALU_WAIT = ALU_WAIT_DEF,
  localparam int unsigned IW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [3:0]        rsp_y,
  output logic [1:0]        alu_s,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  input  logic [3:0]        alu_y
`ifdef ALU_SCHED_CNT_EN
  ,
  output logic [7:0]        op_count
`endif
);

  localparam int unsigned CW = $clog2(ALU_WAIT + 1);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] id_q, id_d;
  logic [3:0]    y_q, y_d;
  logic          vld_q, vld_d;
  logic [1:0]    s_q, s_d;
  logic [3:0]    a_q, a_d;
  logic [3:0]    b_q, b_d;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic [1:0]      op_arr [NREQ];
  logic [3:0]      a_arr  [NREQ];
  logic [3:0]      b_arr  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i] = req_op[2*i +: 2];
    assign a_arr[i]  = req_a[4*i +: 4];
    assign b_arr[i]  = req_b[4*i +: 4];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The ALU operand registers double as the captured request; they are zero outside EXEC.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    y_d       = y_q;
    vld_d     = vld_q;
    s_d       = s_q;
    a_d       = a_q;
    b_d       = b_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (!rst && (|req_valid)) begin
          req_ready = grant;
          s_d       = op_arr[gidx];
          a_d       = a_arr[gidx];
          b_d       = b_arr[gidx];
          id_d      = gidx;
          cnt_d     = CW'(ALU_WAIT - 1);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          y_d     = alu_y;
          ptr_d   = (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
          s_d     = '0;
          a_d     = '0;
          b_d     = '0;
          vld_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      id_q  <= '0;
      y_q   <= '0;
      vld_q <= 1'b0;
      s_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      id_q  <= id_d;
      y_q   <= y_d;
      vld_q <= vld_d;
      s_q   <= s_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_y     = y_q;
  assign alu_s     = s_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;

`ifdef ALU_SCHED_CNT_EN
  logic [7:0] opc_q, opc_d;

  // Completed-op counter, saturating at 255.
  always_comb begin
    opc_d = opc_q;
    if ((state_q == RESP) && rsp_ready && (opc_q != 8'hFF)) begin
      opc_d = opc_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_q <= '0;
    end else begin
      opc_q <= opc_d;
    end
  end

  assign op_count = opc_q;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed vectors, multi-cycle corner cases,
// and randomized traffic against a transaction-level reference model.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int N = 4;
  localparam int W = 2;

  typedef struct {
    int         r;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [2*N-1:0] req_op;
  logic [4*N-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [3:0]     rsp_y;
  logic [1:0]     alu_s;
  logic [3:0]     alu_a, alu_b, alu_y;
`ifdef ALU_SCHED_CNT_EN
  logic [7:0]     op_count;
`endif

  logic [1:0] op_v [N];
  logic [3:0] a_v  [N];
  logic [3:0] b_v  [N];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: one op in flight, round-robin pointer as a plain integer.
  int         m_ptr, m_left, m_id, hs_cnt;
  bit         m_busy, m_rsp, rand_keep, prev_rv;
  logic [1:0] m_s;
  logic [3:0] m_a, m_b, m_y;
  int         acc_cyc, rise_cyc;
  int         grant_log[$], rsp_id_log[$], rsp_cyc_log[$];
  logic [3:0] rsp_y_log[$];
  vec_t       tbl [8];

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_op[2*i +: 2] = op_v[i];
    assign req_a[4*i +: 4]  = a_v[i];
    assign req_b[4*i +: 4]  = b_v[i];
  end

  function automatic logic [3:0] alu_f(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      2'd0:    return 4'((int'(a) + int'(b)) % 16);
      2'd1:    return 4'((int'(a) - int'(b) + 16) % 16);
      2'd2:    return (a < b) ? 4'd1 : 4'd0;
      default: return a & b;
    endcase
  endfunction

  always_comb alu_y = alu_f(alu_s, alu_a, alu_b);

  alu_sched #(.NREQ(N), .ALU_WAIT(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .alu_s     (alu_s),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y)
`ifdef ALU_SCHED_CNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'(0));
    chk({tag, "_rsp_y"},     32'(rsp_y),     32'(0));
    chk({tag, "_alu_sab"},   32'({alu_s, alu_a, alu_b}), 32'(0));
`ifdef ALU_SCHED_CNT_EN
    chk({tag, "_op_count"},  32'(op_count),  32'(0));
`endif
  endtask

  task automatic model_reset();
    m_ptr = 0; m_busy = 0; m_rsp = 0; m_left = 0; hs_cnt = 0; prev_rv = 0;
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    op_v[r] = op; a_v[r] = a; b_v[r] = b; req_valid[r] = 1'b1;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model across the edge.
  task automatic step();
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    g = -1;
    er = '0;
    if (!m_busy && !m_rsp) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
    if (m_rsp) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_y",  32'(rsp_y),  32'(m_y));
    end
    chk("alu_s", 32'(alu_s), m_busy ? 32'(m_s) : 32'(0));
    chk("alu_a", 32'(alu_a), m_busy ? 32'(m_a) : 32'(0));
    chk("alu_b", 32'(alu_b), m_busy ? 32'(m_b) : 32'(0));
`ifdef ALU_SCHED_CNT_EN
    chk("op_count", 32'(op_count), 32'((hs_cnt > 255) ? 255 : hs_cnt));
`endif
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        grant_log.push_back(i);
        acc_cyc = cyc;
      end
    end
    if (rsp_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      rsp_id_log.push_back(int'(rsp_id));
      rsp_y_log.push_back(rsp_y);
      rsp_cyc_log.push_back(cyc);
    end
    if (m_rsp) begin
      if (rsp_ready) begin m_rsp = 0; hs_cnt++; end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_rsp = 1; m_ptr = (m_id + 1) % N; end
    end else if (g >= 0) begin
      m_busy = 1; m_left = W; m_id = g;
      m_s = op_v[g]; m_a = a_v[g]; m_b = b_v[g];
      m_y = alu_f(m_s, m_a, m_b);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) begin
      if (rand_keep && $urandom_range(1) == 1) begin
        op_v[g] = 2'($urandom); a_v[g] = 4'($urandom); b_v[g] = 4'($urandom);
      end else begin
        req_valid[g] = 1'b0;
      end
    end
  endtask

  task automatic run_until(input string name, input int n, input int budget);
    int b;
    b = budget;
    while (rsp_id_log.size() < n && b > 0) begin
      step();
      b--;
    end
    chk({name, "_responses"}, 32'(rsp_id_log.size()), 32'(n));
  endtask

  task automatic clear_logs();
    grant_log.delete(); rsp_id_log.delete(); rsp_y_log.delete(); rsp_cyc_log.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{0, OP_ADD, 4'd9,  4'd8,  4'd1},
      '{1, OP_SUB, 4'd5,  4'd3,  4'd2},
      '{2, OP_AND, 4'd12, 4'd10, 4'd8},
      '{3, OP_SUB, 4'd0,  4'd1,  4'd15},
      '{0, OP_ADD, 4'd15, 4'd15, 4'd14},
      '{1, OP_CMP, 4'd3,  4'd9,  4'd1},
      '{2, OP_CMP, 4'd9,  4'd3,  4'd0},
      '{3, OP_AND, 4'd15, 4'd6,  4'd6}
    };
    rst = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    rand_keep = 0;
    for (int i = 0; i < N; i++) begin op_v[i] = '0; a_v[i] = '0; b_v[i] = '0; end
    model_reset();
    #1 rst = 1'b1;
    req_valid = '1;
    #1 chk_rst_outputs("por");
    req_valid = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Round robin from ptr 0: all four subtracts in flight order 0..3.
    clear_logs();
    set_req(0, OP_SUB, 4'd5, 4'd3);
    set_req(1, OP_SUB, 4'd7, 4'd1);
    set_req(2, OP_SUB, 4'd2, 4'd2);
    set_req(3, OP_SUB, 4'd15, 4'd4);
    rsp_ready = 1'b1;
    run_until("rr", 4, 40);
    if (rsp_id_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("rr_id", 32'(rsp_id_log[i]), 32'(i));
      chk("rr_y0", 32'(rsp_y_log[0]), 32'(2));
      chk("rr_y1", 32'(rsp_y_log[1]), 32'(6));
      chk("rr_y2", 32'(rsp_y_log[2]), 32'(0));
      chk("rr_y3", 32'(rsp_y_log[3]), 32'(11));
      for (int i = 1; i < 4; i++) chk("rr_spacing", 32'(rsp_cyc_log[i] - rsp_cyc_log[i-1]), 32'(W + 2));
    end

    // Directed single-op vectors: result, id, single ready pulse and latency.
    foreach (tbl[t]) begin
      clear_logs();
      set_req(tbl[t].r, tbl[t].op, tbl[t].a, tbl[t].b);
      run_until("vec", 1, 20);
      if (rsp_id_log.size() == 1) begin
        chk("vec_id", 32'(rsp_id_log[0]), 32'(tbl[t].r));
        chk("vec_y",  32'(rsp_y_log[0]),  32'(tbl[t].y));
      end
      chk("vec_ready_pulses", 32'(grant_log.size()), 32'(1));
      chk("vec_latency", 32'(rise_cyc - acc_cyc), 32'(W + 1));
    end

    // Backpressure: response held for 10 cycles while another requester waits.
    clear_logs();
    rsp_ready = 1'b0;
    set_req(1, OP_ADD, 4'd7, 4'd7);
    for (int b = 0; b < 10 && !prev_rv; b++) step();
    chk("bp_rsp_seen", 32'(prev_rv), 32'(1));
    set_req(2, OP_AND, 4'd5, 4'd3);
    repeat (10) step();
    chk("bp_no_accept", 32'(rsp_id_log.size()), 32'(0));
    chk("bp_no_grant2", 32'(grant_log.size()), 32'(1));
    rsp_ready = 1'b1;
    run_until("bp_first", 1, 2);
    run_until("bp_second", 2, 20);
    if (rsp_id_log.size() == 2) begin
      chk("bp_id0", 32'(rsp_id_log[0]), 32'(1));
      chk("bp_y0",  32'(rsp_y_log[0]),  32'(14));
      chk("bp_id1", 32'(rsp_id_log[1]), 32'(2));
      chk("bp_y1",  32'(rsp_y_log[1]),  32'(1));
    end

    // Fairness wrap: pointer now 3, requesters 1 and 3 pending.
    clear_logs();
    set_req(1, OP_SUB, 4'd1, 4'd2);
    set_req(3, OP_ADD, 4'd1, 4'd2);
    run_until("wrap", 2, 30);
    if (grant_log.size() == 2) begin
      chk("wrap_grant0", 32'(grant_log[0]), 32'(3));
      chk("wrap_grant1", 32'(grant_log[1]), 32'(1));
    end
    if (rsp_id_log.size() == 2) begin
      chk("wrap_y0", 32'(rsp_y_log[0]), 32'(3));
      chk("wrap_y1", 32'(rsp_y_log[1]), 32'(15));
    end

    // Reset in the middle of EXEC discards the op.
    clear_logs();
    set_req(3, OP_ADD, 4'd4, 4'd4);
    step();
    chk("mid_accept", 32'(grant_log.size()), 32'(1));
    rst = 1'b1;
    req_valid = '1;
    #1 chk_rst_outputs("mid_exec");
    model_reset();
    req_valid = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) step();
    chk("mid_no_rsp", 32'(rsp_id_log.size()), 32'(0));
    clear_logs();
    set_req(0, OP_ADD, 4'd1, 4'd1);
    set_req(1, OP_ADD, 4'd2, 4'd2);
    set_req(2, OP_ADD, 4'd3, 4'd3);
    set_req(3, OP_ADD, 4'd4, 4'd4);
    run_until("post_rst", 4, 40);
    if (grant_log.size() > 0) chk("post_rst_first_grant", 32'(grant_log[0]), 32'(0));

    // Randomized traffic against the model.
    clear_logs();
    rand_keep = 1;
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) set_req(i, 2'($urandom), 4'($urandom), 4'($urandom));
        end else if ($urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      step();
    end
    chk("rand_progress", 32'(rsp_id_log.size() > 100), 32'(1));

`ifdef ALU_SCHED_CNT_EN
    rsp_ready = 1'b1;
    for (int b = 0; b < 3000 && hs_cnt < 300; b++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) set_req(i, 2'($urandom), 4'($urandom), 4'($urandom));
      end
      step();
    end
    @(negedge clk);
    chk("op_count_sat", 32'(op_count), 32'(255));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
